// File: rtl/simple_uart_tx.sv
// -----------------------------------------------------------------------------
// simple_uart_tx
// Memory-mapped 8N1 UART transmitter on the PicoRV32 native memory bus.
// Firmware console writes are buffered in a TX FIFO and serialised on uart_txd.
// Each accepted byte is also mirrored on tx_byte/tx_strobe so a simulation
// environment can print the console stream.
//
// Register map (offset = mem_addr[3:2]):
//   0 DATA    W: push mem_wdata[7:0] when mem_wstrb[0]; reads return 0
//   1 STATUS  R: [0] fifo_full, [1] fifo_empty, [2] busy, [15:8] fifo count
//   2 DIV     R/W: [15:0] bit period in clk cycles, values below 2 stored as 2
//   3 --      reads 0, writes ignored, still acknowledged
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   sel        address-decode hit for this block, qualifies mem_valid
//   mem_valid  bus request valid
//   mem_addr   byte address, only [3:2] decoded
//   mem_wdata  write data
//   mem_wstrb  byte strobes, all-zero means read
//   mem_rdata  read data, non-zero only while mem_ready is high
//   mem_ready  one-cycle transfer-complete pulse
//   uart_txd   serial output, idles high
//   tx_byte    last byte accepted into the transmit path
//   tx_strobe  one-cycle pulse whenever tx_byte is updated
// -----------------------------------------------------------------------------
module simple_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        uart_txd,
  output logic [7:0]  tx_byte,
  output logic        tx_strobe
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [15:0]   DIV_RESET = 16'(DEFAULT_DIV);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Bus-side registers
  logic        mem_ready_r;
  logic [31:0] mem_rdata_r;
  logic [7:0]  tx_byte_r;
  logic        tx_strobe_r;
  logic [15:0] div_r;

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Transmit FSM state
  tx_state_t   state_r;
  logic        txd_r;
  logic [15:0] timer_r;
  logic [15:0] div_lat_r;
  logic [7:0]  shift_r;
  logic [2:0]  bit_idx_r;

  // Combinational control
  logic [1:0]  offset_s;
  logic        req_s;
  logic        is_write_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        busy_s;
  logic        start_slot_s;
  logic        pop_s;
  logic        push_want_s;
  logic        stall_s;
  logic        accept_s;
  logic        push_s;
  logic        bypass_s;
  logic        fifo_wr_s;
  logic        frame_start_s;
  logic [7:0]  next_byte_s;
  logic [7:0]  status_cnt_s;
  logic [31:0] rd_val_s;
  logic [15:0] div_wr_s;
  logic [15:0] div_clamped_s;
  logic        div_we_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

  // Request qualification, FIFO flow control and frame-start decisions.
  always_comb begin
    offset_s     = mem_addr[3:2];
    req_s        = sel && mem_valid && !mem_ready_r;
    is_write_s   = (mem_wstrb != 4'b0000);
    fifo_empty_s = (count_r == CNT_ZERO);
    fifo_full_s  = (count_r == DEPTH_CNT);
    busy_s       = (state_r != ST_IDLE);
    // A new frame may begin while idle or on the last cycle of a stop bit.
    start_slot_s = (state_r == ST_IDLE) || ((state_r == ST_STOP) && (timer_r == 16'd0));
    pop_s        = start_slot_s && !fifo_empty_s;
    push_want_s  = req_s && (offset_s == OFS_DATA) && mem_wstrb[0];
    // A pop in the same cycle frees a slot, so a full FIFO only stalls without one.
    stall_s      = push_want_s && fifo_full_s && !pop_s;
    accept_s     = req_s && !stall_s;
    push_s       = push_want_s && !stall_s;
    // An empty FIFO at a frame-start slot hands the byte straight to the
    // shifter, so the start bit appears the cycle after acceptance.
    bypass_s      = push_s && start_slot_s && fifo_empty_s;
    fifo_wr_s     = push_s && !bypass_s;
    frame_start_s = pop_s || bypass_s;
    status_cnt_s  = 8'(count_r);
  end

  // Source of the byte loaded into the shifter at a frame start.
  always_comb begin
    next_byte_s = 8'h00;
    if (pop_s) begin
      next_byte_s = fifo_mem_r[rd_ptr_r];
    end else begin
      next_byte_s = mem_wdata[7:0];
    end
  end

  // Read-data mux; writes return zero.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    if (!is_write_s) begin
      case (offset_s)
        OFS_STATUS: rd_val_s = {16'h0000, status_cnt_s, 5'b00000, busy_s, fifo_empty_s, fifo_full_s};
        OFS_DIV:    rd_val_s = {16'h0000, div_r};
        default:    rd_val_s = 32'h0000_0000;
      endcase
    end else begin
      rd_val_s = 32'h0000_0000;
    end
  end

  // DIV write value honouring byte strobes, clamped to a minimum of 2.
  always_comb begin
    div_wr_s[15:8] = mem_wstrb[1] ? mem_wdata[15:8] : div_r[15:8];
    div_wr_s[7:0]  = mem_wstrb[0] ? mem_wdata[7:0]  : div_r[7:0];
    div_we_s       = accept_s && (offset_s == OFS_DIV) && (mem_wstrb[1:0] != 2'b00);
    if (div_wr_s < 16'd2) begin
      div_clamped_s = 16'd2;
    end else begin
      div_clamped_s = div_wr_s;
    end
  end

  // Bus response, DIV register and console mirror.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
      tx_byte_r   <= 8'h00;
      tx_strobe_r <= 1'b0;
      div_r       <= DIV_RESET;
    end else begin
      mem_ready_r <= accept_s;
      mem_rdata_r <= accept_s ? rd_val_s : 32'h0000_0000;
      tx_strobe_r <= push_s;
      if (push_s) begin
        tx_byte_r <= mem_wdata[7:0];
      end
      if (div_we_s) begin
        div_r <= div_clamped_s;
      end
    end
  end

  // TX FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
    end else begin
      if (fifo_wr_s) begin
        fifo_mem_r[wr_ptr_r] <= mem_wdata[7:0];
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({fifo_wr_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Transmit FSM: frame sequencing, bit timer and registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      txd_r     <= 1'b1;
      timer_r   <= 16'd0;
      div_lat_r <= DIV_RESET;
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          txd_r <= 1'b1;
          if (frame_start_s) begin
            // DIV is sampled only here, so mid-frame writes wait for the next frame.
            state_r   <= ST_START;
            txd_r     <= 1'b0;
            shift_r   <= next_byte_s;
            div_lat_r <= div_r;
            timer_r   <= div_r - 16'd1;
          end
        end
        ST_START: begin
          if (timer_r == 16'd0) begin
            state_r   <= ST_DATA;
            txd_r     <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
            bit_idx_r <= 3'd0;
            timer_r   <= div_lat_r - 16'd1;
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (timer_r == 16'd0) begin
            timer_r <= div_lat_r - 16'd1;
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
              txd_r   <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              txd_r     <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (timer_r == 16'd0) begin
            if (frame_start_s) begin
              // Chain straight into the next start bit with no idle gap.
              state_r   <= ST_START;
              txd_r     <= 1'b0;
              shift_r   <= next_byte_s;
              div_lat_r <= div_r;
              timer_r   <= div_r - 16'd1;
            end else begin
              state_r <= ST_IDLE;
              txd_r   <= 1'b1;
            end
          end else begin
            timer_r <= timer_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          txd_r   <= 1'b1;
        end
      endcase
    end
  end

  assign mem_ready = mem_ready_r;
  assign mem_rdata = mem_rdata_r;
  assign uart_txd  = txd_r;
  assign tx_byte   = tx_byte_r;
  assign tx_strobe = tx_strobe_r;

endmodule

// File: tb/tb_simple_uart_tx.sv
// Scoreboard bench for simple_uart_tx (FIFO_DEPTH=4 so the FIFO fills quickly).
// Stimulus pushes expected bus responses, console bytes and serial frames into
// queues; independent monitors pop and compare as the DUT presents them.
module tb_simple_uart_tx;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV    = 2'd2;
  localparam logic [1:0] OFS_RSVD   = 2'd3;
  localparam int BUS_BUDGET = 2000;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        uart_txd;
  logic [7:0]  tx_byte;
  logic        tx_strobe;

  simple_uart_tx #(.FIFO_DEPTH(4), .DEFAULT_DIV(104)) dut (
    .clk(clk), .reset(reset), .sel(sel), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .uart_txd(uart_txd),
    .tx_byte(tx_byte), .tx_strobe(tx_strobe)
  );

  typedef struct {
    logic [7:0] b;
    int         div;
    bit         b2b;
  } frame_t;

  logic [31:0] exp_rd_q [$];
  logic [7:0]  exp_st_q [$];
  frame_t      exp_fr_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;
  int last_lat;
  int ready_cyc;
  logic txd_at_ready;
  int last_start_cyc = 0;
  int last_end_cyc = -100;
  int mon_state = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Issue one bus transfer; caller is at posedge+1 and returns at posedge+1.
  task automatic bus_xfer(input logic [1:0] ofs, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] expv);
    bit got;
    exp_rd_q.push_back(expv);
    sel = 1'b1; mem_valid = 1'b1;
    mem_addr = 32'h0200_0000 | {28'h000_0000, ofs, 2'b00};
    mem_wdata = wd; mem_wstrb = ws;
    got = 1'b0; last_lat = 0;
    while (!got && last_lat < BUS_BUDGET) begin
      @(negedge clk);
      last_lat++;
      if (mem_ready === 1'b1) got = 1'b1;
    end
    ready_cyc = cyc;
    txd_at_ready = uart_txd;
    if (!got) begin
      checks++; errors++;
      $display("FAIL bus_timeout: no mem_ready after %0d cycles (ofs %0d)", last_lat, ofs);
    end
    @(posedge clk); #1;
    sel = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'b0000; mem_wdata = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_fr_q.size() != 0 || mon_state != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", (n < budget) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic expect_byte(input logic [7:0] b, input int div, input bit b2b);
    frame_t f;
    f.b = b; f.div = div; f.b2b = b2b;
    exp_st_q.push_back(b);
    exp_fr_q.push_back(f);
  endtask

  // Bus monitor: every mem_ready pulse pops one expected read value.
  initial begin
    forever begin
      @(negedge clk);
      if (started && !reset) begin
        if (mem_ready === 1'b1) begin
          if (exp_rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected_ready: rdata 0x%08h", mem_rdata);
          end else begin
            chk("bus_rdata", mem_rdata, exp_rd_q.pop_front());
          end
        end else begin
          chk("rdata_zero_idle", mem_rdata, 32'h0);
        end
      end
    end
  end

  // Console monitor: every tx_strobe pops one expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (started && !reset && tx_strobe === 1'b1) begin
        if (exp_st_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe_unexpected: tx_byte 0x%02h", tx_byte);
        end else begin
          chk("tx_byte", {24'h0, tx_byte}, {24'h0, exp_st_q.pop_front()});
        end
      end
    end
  end

  // Serial monitor: checks every cycle of each 10*div frame and inter-frame gaps.
  initial begin
    frame_t cur;
    int ctr, bit_i, gap, bad_at;
    logic lvl;
    forever begin
      @(negedge clk);
      if (reset || !started) begin
        mon_state = 0;
      end else if (mon_state == 0) begin
        if (uart_txd !== 1'b1) begin
          if (exp_fr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_unexpected: txd low at cycle %0d with no byte queued", cyc);
            mon_state = 2;
          end else begin
            cur = exp_fr_q.pop_front();
            gap = cyc - last_end_cyc;
            last_start_cyc = cyc;
            ctr = 0; bad_at = -1;
            mon_state = 1;
          end
        end
      end else if (mon_state == 2) begin
        if (uart_txd === 1'b1) mon_state = 0;
      end
      if (mon_state == 1 && started && !reset) begin
        bit_i = ctr / cur.div;
        if (bit_i == 0) lvl = 1'b0;
        else if (bit_i == 9) lvl = 1'b1;
        else lvl = cur.b[bit_i-1];
        if (uart_txd !== lvl && bad_at < 0) bad_at = ctr;
        ctr++;
        if (ctr == 10 * cur.div) begin
          checks++;
          if (bad_at >= 0 || (cur.b2b && gap != 1)) begin
            errors++;
            $display("FAIL frame 0x%02h div %0d: first bad cycle %0d (-1 none), gap %0d expected %0d",
                     cur.b, cur.div, bad_at, gap, cur.b2b ? 1 : gap);
          end
          last_end_cyc = cyc;
          mon_state = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 1'b0; mem_valid = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'b0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_uart_txd", {31'h0, uart_txd}, 32'h1);
    chk("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
    chk("rst_tx_strobe", {31'h0, tx_strobe}, 32'h0);
    started = 1'b1;
    @(posedge clk); #1;
    bus_xfer(OFS_STATUS, 32'h0, 4'b0000, 32'h0000_0002);
    bus_xfer(OFS_DIV, 32'h0, 4'b0000, 32'd104);

    // 1: single byte at DIV=4
    bus_xfer(OFS_DIV, 32'd4, 4'b0011, 32'h0);
    bus_xfer(OFS_DIV, 32'h0, 4'b0000, 32'd4);
    expect_byte(8'h41, 4, 1'b0);
    bus_xfer(OFS_DATA, 32'h41, 4'b0001, 32'h0);
    chk("t1_latency", 32'(last_lat), 32'd2);
    chk("t1_start_bit_at_ready", {31'h0, txd_at_ready}, 32'h0);
    wait_drain(1000);
    bus_xfer(OFS_STATUS, 32'h0, 4'b0000, 32'h0000_0002);

    // 2/6: DIV=8, six back-to-back bytes into a 4-deep FIFO; the sixth stalls
    // and is accepted in the very cycle frame 1 ends and frame 2 pops.
    bus_xfer(OFS_DIV, 32'd8, 4'b0011, 32'h0);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = 8'(8'h11 * (i + 1));
      expect_byte(b, 8, i > 0);
      bus_xfer(OFS_DATA, {24'h0, b}, 4'b0001, 32'h0);
      if (i < 5) chk("t2_no_stall_latency", 32'(last_lat), 32'd2);
    end
    chk("t2_sixth_stalled", (last_lat > 2) ? 32'd1 : 32'd0, 32'd1);
    chk("t6_push_on_pop_cycle", 32'(ready_cyc), 32'(last_start_cyc));
    bus_xfer(OFS_STATUS, 32'h0, 4'b0000, 32'h0000_0405);
    wait_drain(2000);

    // 3: DIV clamp and mid-frame DIV change
    bus_xfer(OFS_DIV, 32'd1, 4'b0011, 32'h0);
    bus_xfer(OFS_DIV, 32'h0, 4'b0000, 32'd2);
    bus_xfer(OFS_DIV, 32'd0, 4'b0011, 32'h0);
    bus_xfer(OFS_DIV, 32'h0, 4'b0000, 32'd2);
    bus_xfer(OFS_DIV, 32'd8, 4'b0011, 32'h0);
    expect_byte(8'hA5, 8, 1'b0);
    bus_xfer(OFS_DATA, 32'hA5, 4'b0001, 32'h0);
    bus_xfer(OFS_DIV, 32'h20, 4'b0011, 32'h0);
    bus_xfer(OFS_DIV, 32'h0, 4'b0000, 32'h20);
    expect_byte(8'h3C, 32, 1'b1);
    bus_xfer(OFS_DATA, 32'h3C, 4'b0001, 32'h0);
    wait_drain(3000);

    // 4: reset during data bit 3 of a DIV=4 frame
    bus_xfer(OFS_DIV, 32'd4, 4'b0011, 32'h0);
    expect_byte(8'hF0, 4, 1'b0);
    bus_xfer(OFS_DATA, 32'hF0, 4'b0001, 32'h0);
    idle(16);
    reset = 1'b1;
    exp_fr_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t4_txd_after_reset", {31'h0, uart_txd}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    bus_xfer(OFS_STATUS, 32'h0, 4'b0000, 32'h0000_0002);
    bus_xfer(OFS_DIV, 32'h0, 4'b0000, 32'd104);

    // 5: reserved offset and non-byte-0 DATA write
    bus_xfer(OFS_RSVD, 32'h0, 4'b0000, 32'h0);
    chk("t5_rsvd_latency", 32'(last_lat), 32'd2);
    bus_xfer(OFS_DATA, 32'h0000_7777, 4'b0010, 32'h0);
    chk("t5_wstrb1_latency", 32'(last_lat), 32'd2);
    bus_xfer(OFS_STATUS, 32'h0000_FFFF, 4'b1111, 32'h0);
    bus_xfer(OFS_RSVD, 32'hFFFF_FFFF, 4'b1111, 32'h0);
    idle(20);
    bus_xfer(OFS_STATUS, 32'h0, 4'b0000, 32'h0000_0002);
    bus_xfer(OFS_DIV, 32'h0, 4'b0000, 32'd104);
    idle(20);

    chk("end_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    chk("end_st_q_empty", 32'(exp_st_q.size()), 32'd0);
    chk("end_fr_q_empty", 32'(exp_fr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
